// File: rtl/spi_clk_pkg.sv
// Shared types and constants for the SPI serial clock generator.
//   state_t : controller state encoding (IDLE, RUN, TAIL)
//   one_fx  : fixed-point value 1.0 for a given number of fractional bits
package spi_clk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam int unsigned ONE_FX_W = 64;

  // 1.0 in unsigned fixed point with frac_bits fractional bits
  function automatic logic [ONE_FX_W-1:0] one_fx(input int unsigned frac_bits);
    return ONE_FX_W'(1) << frac_bits;
  endfunction

endpackage

// File: rtl/spi_frac_accum.sv
// Fractional half-period accumulator for the SPI clock generator.
//   SOURCE_CLK : block clock
//   reset      : synchronous, active-high
//   load       : start of transfer; count<=1.0, target<=divisor, divisor latched
//   step       : advance count by 1.0; on match, advance target by latched divisor
//   divisor    : fixed-point half-period, captured on load
//   match      : combinational, integer parts of count and target are equal
module spi_frac_accum
  import spi_clk_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 7
) (
  input  logic             SOURCE_CLK,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] divisor,
  output logic             match
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(one_fx(FRAC_BITS));

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] div_q;

  // Both registers wrap modulo 2^WIDTH; equality stays valid because
  // target never leads count by more than one half-period.
  always_ff @(posedge SOURCE_CLK) begin
    if (reset) begin
      count  <= '0;
      target <= '0;
      div_q  <= '0;
    end else if (load) begin
      count  <= ONE;
      target <= divisor;
      div_q  <= divisor;
    end else if (step) begin
      count <= count + ONE;
      if (match) begin
        target <= target + div_q;
      end
    end
  end

  assign match = (count[WIDTH-1:FRAC_BITS] == target[WIDTH-1:FRAC_BITS]);

endmodule

// File: rtl/spi_sclk_gen.sv
// Fractional-N SPI serial clock generator with edge count and handshake.
//   SOURCE_CLK, reset : clock, synchronous active-high reset
//   enable            : clock qualifier; low freezes state, pulses forced low
//   divisor, edges    : half-period (fixed point) and edge count, taken on start
//   cpol              : idle level; latched on start, tracked live while idle
//   start, abort      : request / synchronous stop (abort wins)
//   sclk              : serial clock
//   lead_edge/trail_edge : strobes when sclk leaves / returns to idle level
//   busy, done, start_err : status and one-cycle pulses
module spi_sclk_gen
  import spi_clk_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 7,
  parameter int unsigned EDGE_W    = 7
) (
  input  logic              SOURCE_CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  divisor,
  input  logic              cpol,
  input  logic [EDGE_W-1:0] edges,
  input  logic              start,
  input  logic              abort,
  output logic              sclk,
  output logic              lead_edge,
  output logic              trail_edge,
  output logic              busy,
  output logic              done,
  output logic              start_err
);

  state_t            state, state_n;
  logic [EDGE_W-1:0] remaining, remaining_n;
  logic              pol, pol_n;
  logic              sclk_n, lead_n, trail_n, busy_n, done_n, err_n;
  logic              load, step, match;
  logic              div_ok;

  assign div_ok = |divisor[WIDTH-1:FRAC_BITS];

  spi_frac_accum #(
    .WIDTH    (WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_accum (
    .SOURCE_CLK(SOURCE_CLK),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .divisor   (divisor),
    .match     (match)
  );

  // State and output registers
  always_ff @(posedge SOURCE_CLK) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      pol        <= 1'b0;
      sclk       <= 1'b0;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      pol        <= pol_n;
      sclk       <= sclk_n;
      lead_edge  <= lead_n;
      trail_edge <= trail_n;
      busy       <= busy_n;
      done       <= done_n;
      start_err  <= err_n;
    end
  end

  // Next-state and next-output logic; with enable low everything holds
  // and only the strobes drop.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    pol_n       = pol;
    sclk_n      = sclk;
    lead_n      = 1'b0;
    trail_n     = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    load        = 1'b0;
    step        = 1'b0;

    if (enable) begin
      unique case (state)
        IDLE: begin
          sclk_n = cpol;
          if (start && !abort) begin
            if ((edges != '0) && div_ok) begin
              load        = 1'b1;
              pol_n       = cpol;
              remaining_n = edges;
              state_n     = RUN;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        RUN: begin
          step = 1'b1;
          if (match) begin
            sclk_n      = ~sclk;
            remaining_n = remaining - EDGE_W'(1);
            // Leaving the latched idle level is a leading edge
            if (sclk == pol) lead_n = 1'b1;
            else             trail_n = 1'b1;
            if (remaining == EDGE_W'(1)) state_n = TAIL;
          end
        end
        TAIL: begin
          step = 1'b1;
          if (match) begin
            state_n = IDLE;
            done_n  = 1'b1;
            sclk_n  = cpol;
          end
        end
        default: state_n = IDLE;
      endcase

      if (abort) begin
        state_n = IDLE;
        sclk_n  = cpol;
        lead_n  = 1'b0;
        trail_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        load    = 1'b0;
      end
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: vector table, directed sequences
// and randomized transfers against an event-time reference model.
module tb_spi_sclk_gen;

  localparam int unsigned WIDTH  = 12;
  localparam int unsigned FRAC   = 7;
  localparam int unsigned EDGE_W = 7;
  localparam longint unsigned ONE = 64'd1 << FRAC;

  logic              SOURCE_CLK;
  logic              reset, enable, cpol, start, abort;
  logic [WIDTH-1:0]  divisor;
  logic [EDGE_W-1:0] edges;
  logic              sclk, lead_edge, trail_edge, busy, done, start_err;

  spi_sclk_gen #(.WIDTH(WIDTH), .FRAC_BITS(FRAC), .EDGE_W(EDGE_W)) dut (
    .SOURCE_CLK(SOURCE_CLK), .reset(reset), .enable(enable), .divisor(divisor),
    .cpol(cpol), .edges(edges), .start(start), .abort(abort), .sclk(sclk),
    .lead_edge(lead_edge), .trail_edge(trail_edge), .busy(busy), .done(done),
    .start_err(start_err)
  );

  initial SOURCE_CLK = 1'b0;
  always #5 SOURCE_CLK = ~SOURCE_CLK;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  // Reference model: transfer described by start time, D and edge count;
  // toggle n falls floor(n*D) enabled cycles after start, done at (E+1)*D.
  logic            m_busy, m_sclk, m_lead, m_trail, m_done, m_err;
  longint unsigned m_t, m_d, m_e, m_end;

  task automatic model_update();
    m_lead = 0; m_trail = 0; m_done = 0; m_err = 0;
    if (reset) begin
      m_busy = 0; m_sclk = 0;
    end else if (enable) begin
      if (abort) begin
        m_busy = 0; m_sclk = cpol;
      end else if (!m_busy) begin
        m_sclk = cpol;
        if (start) begin
          if (edges == 0 || longint'(divisor) < ONE) m_err = 1;
          else begin
            m_busy = 1; m_t = 0; m_d = longint'(divisor); m_e = longint'(edges);
            m_end = ((m_e + 1) * m_d) >> FRAC;
          end
        end
      end else begin
        m_t++;
        for (longint unsigned n = 1; n <= m_e; n++) begin
          if (((n * m_d) >> FRAC) == m_t) begin
            m_sclk = ~m_sclk;
            if (n % 2 == 1) m_lead = 1; else m_trail = 1;
          end
        end
        if (m_t == m_end) begin
          m_busy = 0; m_done = 1; m_sclk = cpol;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge SOURCE_CLK);
    model_update();
    #1;
    chk("sclk", 128'(sclk), 128'(m_sclk));
    chk("lead_edge", 128'(lead_edge), 128'(m_lead));
    chk("trail_edge", 128'(trail_edge), 128'(m_trail));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("done", 128'(done), 128'(m_done));
    chk("start_err", 128'(start_err), 128'(m_err));
  endtask

  task automatic do_start(input logic [WIDTH-1:0] d, input int e, input logic cp);
    divisor = d; edges = EDGE_W'(e); cpol = cp; start = 1; step(); start = 0;
  endtask

  // Run n cycles after start, with enable low for steps [dis_from, dis_from+dis_len)
  task automatic run_seq(input int n, input int dis_from, input int dis_len,
                         output logic [127:0] tog, output logic [127:0] ld,
                         output logic [127:0] tr, output logic [127:0] dn);
    logic prev;
    tog = '0; ld = '0; tr = '0; dn = '0;
    prev = sclk;
    for (int i = 1; i <= n; i++) begin
      enable = !(i >= dis_from && i < dis_from + dis_len);
      step();
      if (sclk != prev) tog[i] = 1'b1;
      ld[i] = lead_edge; tr[i] = trail_edge; dn[i] = done;
      prev = sclk;
    end
    enable = 1;
  endtask

  typedef struct {
    logic rst, en, st, ab, cp;
    logic [WIDTH-1:0] div;
    int edg;
    logic e_sclk, e_busy, e_err;
  } vec_t;

  vec_t vecs[$];
  logic [127:0] tog, ld, tr, dn, exp_tog;

  initial begin
    reset = 1; enable = 1; cpol = 0; start = 0; abort = 0;
    divisor = 12'h200; edges = 7'd4;
    m_busy = 0; m_sclk = 0; m_t = 0; m_d = 0; m_e = 0; m_end = 0;
    m_lead = 0; m_trail = 0; m_done = 0; m_err = 0;

    // Reset state
    step();
    chk("rst_sclk", 128'(sclk), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_pulses", {lead_edge, trail_edge, done, start_err}, 0);
    reset = 0;

    // Idle behaviour, rejects, abort priority, 1.0 boundary, back-to-back
    vecs.push_back('{1,1,0,0,1,12'h200,4, 0,0,0});
    vecs.push_back('{0,1,0,0,1,12'h200,4, 1,0,0});
    vecs.push_back('{0,1,1,0,1,12'h200,0, 1,0,1});
    vecs.push_back('{0,1,1,0,0,12'h07F,4, 0,0,1});
    vecs.push_back('{0,0,1,0,1,12'h07F,4, 0,0,0});
    vecs.push_back('{0,1,1,1,1,12'h07F,0, 1,0,0});
    vecs.push_back('{0,1,0,0,0,12'h200,4, 0,0,0});
    vecs.push_back('{0,1,1,0,0,12'h080,1, 0,1,0});
    vecs.push_back('{0,1,0,0,0,12'h080,1, 1,1,0});
    vecs.push_back('{0,1,0,0,0,12'h080,1, 0,0,0});
    vecs.push_back('{0,1,1,0,0,12'h200,4, 0,1,0});
    vecs.push_back('{1,1,0,0,0,12'h200,4, 0,0,0});
    foreach (vecs[i]) begin
      reset = vecs[i].rst; enable = vecs[i].en; start = vecs[i].st;
      abort = vecs[i].ab; cpol = vecs[i].cp; divisor = vecs[i].div;
      edges = EDGE_W'(vecs[i].edg);
      step();
      chk($sformatf("vec%0d_sclk", i), 128'(sclk), 128'(vecs[i].e_sclk));
      chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].e_busy));
      chk($sformatf("vec%0d_err", i), 128'(start_err), 128'(vecs[i].e_err));
    end
    reset = 0; start = 0; abort = 0; enable = 1;
    step();

    // D=4.0, 4 edges, cpol=0
    do_start(12'h200, 4, 0);
    run_seq(22, 0, 0, tog, ld, tr, dn);
    chk("d4_tog", tog, (128'd1<<4)|(128'd1<<8)|(128'd1<<12)|(128'd1<<16));
    chk("d4_lead", ld, (128'd1<<4)|(128'd1<<12));
    chk("d4_trail", tr, (128'd1<<8)|(128'd1<<16));
    chk("d4_done", dn, 128'd1<<20);

    // D=2.5, 6 edges, cpol=1
    do_start(12'h140, 6, 1);
    run_seq(20, 0, 0, tog, ld, tr, dn);
    chk("d25_tog", tog, (128'd1<<2)|(128'd1<<5)|(128'd1<<7)|(128'd1<<10)|(128'd1<<12)|(128'd1<<15));
    chk("d25_lead", ld, (128'd1<<2)|(128'd1<<7)|(128'd1<<12));
    chk("d25_done", dn, 128'd1<<17);
    chk("d25_idle_hi", 128'(sclk), 1);

    // enable low for 5 cycles mid-RUN
    do_start(12'h200, 4, 0);
    run_seq(28, 7, 5, tog, ld, tr, dn);
    chk("en_tog", tog, (128'd1<<4)|(128'd1<<13)|(128'd1<<17)|(128'd1<<21));
    chk("en_done", dn, 128'd1<<25);

    // abort after 3rd edge with simultaneous start
    do_start(12'h200, 8, 1);
    run_seq(13, 0, 0, tog, ld, tr, dn);
    chk("ab_pre_tog", tog, (128'd1<<4)|(128'd1<<8)|(128'd1<<12));
    abort = 1; start = 1; step(); abort = 0; start = 0;
    chk("ab_busy", 128'(busy), 0);
    chk("ab_sclk", 128'(sclk), 1);
    chk("ab_pulses", {done, lead_edge, trail_edge}, 0);
    run_seq(40, 0, 0, tog, ld, tr, dn);
    chk("ab_after", {tog, dn}, 0);

    // Wrap: D=3.0, 30 edges crosses the 5-bit integer range several times
    do_start(12'h180, 30, 0);
    run_seq(95, 0, 0, tog, ld, tr, dn);
    exp_tog = '0;
    for (int n = 1; n <= 30; n++) exp_tog[3*n] = 1'b1;
    chk("wrap_tog", tog, exp_tog);
    chk("wrap_done", dn, 128'd1<<93);

    // reset mid-RUN
    do_start(12'h180, 10, 1);
    run_seq(4, 0, 0, tog, ld, tr, dn);
    reset = 1; step(); reset = 0;
    chk("rstrun_out", {sclk, lead_edge, trail_edge, busy, done, start_err}, 0);
    step();

    // Randomized transfers with enable gaps, aborts, noise on start and cpol
    for (int x = 0; x < 40; x++) begin
      do_start(WIDTH'($urandom_range(128, 767)), $urandom_range(1, 12), 1'($urandom));
      for (int c = 0; c < 150 && m_busy; c++) begin
        enable = ($urandom_range(0, 7) != 0);
        abort  = ($urandom_range(0, 199) == 0);
        start  = ($urandom_range(0, 15) == 0);
        cpol   = ($urandom_range(0, 9) == 0) ? ~cpol : cpol;
        step();
      end
      enable = 1; abort = 0; start = 0;
      step();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

Parametrised fractional-N serial clock generator for the SPI master. It produces an SCLK of programmable fixed-point half-period with configurable idle polarity (CPOL), and emits exactly a programmed number of edges per transfer. It provides start/busy/done handshaking, leading/trailing edge strobes and abort. It sits between the SPI control FSM and the shift register and replaces the free-running divider used by earlier SPI revisions.

## Interface
- WIDTH, 32: accumulator/divisor width, unsigned fixed point.
- FRAC_BITS, 7: fractional bits of divisor; integer part is [WIDTH-1:FRAC_BITS].
- EDGE_W, 7: width of edge-count field (max 2^EDGE_W-1 edges per transfer).
- SOURCE_CLK  in  1  block clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  synchronous clock qualifier; low freezes all state and holds all outputs; pulses forced low.
- divisor  in  WIDTH  SCLK half-period in SOURCE_CLK cycles, fixed point; sampled on accepted start.
- cpol  in  1  SCLK idle level; sampled on accepted start, followed live while IDLE.
- edges  in  EDGE_W  number of SCLK edges to generate; sampled on accepted start.
- start  in  1  request; accepted only in IDLE with enable=1, edges!=0, integer(divisor)>=1.
- abort  in  1  synchronous stop; return to IDLE next cycle, no done.
- sclk  out  1  serial clock.
- lead_edge  out  1  one-cycle pulse when sclk leaves idle level.
- trail_edge  out  1  one-cycle pulse when sclk returns to idle level.
- busy  out  1  high in RUN and TAIL.
- done  out  1  one-cycle pulse on TAIL→IDLE.
- start_err  out  1  one-cycle pulse when start is rejected for bad edges/divisor in IDLE.

## Operation
- Reset values: sclk=0, lead_edge=0, trail_edge=0, busy=0, done=0, start_err=0, state=IDLE, count=0, target=0, remaining=0.
- IDLE: sclk<=cpol each enabled cycle. Accepted start: count<=ONE (1<<FRAC_BITS), target<=divisor, remaining<=edges, pol latched, →RUN.
- Start in IDLE with edges==0 or integer(divisor)==0: start_err pulse, stay IDLE. Start while busy is ignored silently.
- RUN, each enabled cycle: count<=count+ONE. If count[WIDTH-1:FRAC_BITS]==target[WIDTH-1:FRAC_BITS]: sclk toggles, target<=target+divisor, remaining<=remaining-1, lead_edge or trail_edge pulses. Pulse choice is relative to latched pol. If remaining==1 at that toggle, →TAIL.
- TAIL: count continues; on next compare match (one further half-period) →IDLE with done pulse; no toggle. sclk is already at its final level.
- Odd edge count leaves sclk at non-idle level through TAIL; on return to IDLE sclk<=cpol.
- Arithmetic: count and target wrap modulo 2^WIDTH; equality compare remains correct across wrap. Fractional bits carry so average half-period equals divisor exactly.
- abort (any state, enable=1): →IDLE, sclk<=cpol, busy<=0, no done, no strobes. abort and start in the same cycle: abort wins, start ignored.
- reset mid-transfer: all state to reset values regardless of enable.

## Timing
- Start accepted at edge k: busy=1 after edge k. First toggle is visible after edge k+floor(D). Toggle n is visible after edge k+floor(n·D).
- Strobes are high in the same cycle sclk first shows its new level.
- done is high for the cycle after edge k+floor((edges+1)·D); busy falls at that same edge.
- Back-to-back: start may be accepted in the cycle done is high (state is IDLE).
- enable low for m cycles delays all subsequent events by exactly m cycles.

## Structure
- Package spi_clk_pkg: state localparams IDLE=2'd0, RUN=2'd1, TAIL=2'd2; function one_fx(FRAC_BITS) returning the ONE constant.
- Sub-module spi_frac_accum: count/target registers, add, integer-part equality compare. Ports are load, step, divisor and match.
- Top holds the FSM, remaining counter, sclk/pol and strobe registers.

## Test plan
- D=0x200 (4.0), edges=4, cpol=0, start at k → sclk rises k+4, falls k+8, rises k+12, falls k+16; lead at k+4,k+12; trail at k+8,k+16; done at k+20.
- D=0x140 (2.5), edges=6, cpol=1 → toggles at k+2,5,7,10,12,15; intervals alternate 2/3; sclk idles high; done at k+17.
- edges=0 or D=0x07F with start → start_err pulse, busy stays 0, sclk=cpol.
- abort after 3rd edge, with start asserted in the same cycle → next cycle state IDLE, sclk=cpol, no done, no start accepted.
- enable low 5 cycles mid-RUN (D=4.0, edges=4) → every subsequent toggle and done shifted by exactly 5; outputs frozen and pulses suppressed while low.
- Wrap: preload so target crosses 2^WIDTH with D=3.0 → toggle spacing stays 3 across wrap; reset mid-RUN → all outputs to reset values next edge.
